controle_clock: RTL

Clock-enable controller for the processor core: generates a one-cycle CLKEN strobe in CLKFPGA's domain, replacing a gated/divided clock. Two modes: automatic, a periodic strobe every DIVISOR+1 cycles that a breakpoint can stop, and manual, a debounced key that issues a burst of STEPS strobes. Sits between the board inputs (KEY, mode switch) and every enable-gated register in the core; also exports state and a strobe counter for display.

---
 rtl/controle_clock.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/controle_clock.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : controle_clock
// Purpose  : Clock-enable strobe generator with auto (divided, haltable) and
//            manual (debounced key, burst of STEPS strobes) modes.
// Revision : 1.0 - initial release
// ============================================================================
module controle_clock #(
    parameter int DIVISOR  = 10000000,
    parameter int DEBOUNCE = 500000,
    parameter int CNTW     = 24
) (
    input  logic        CLKFPGA,
    input  logic        RST,
    input  logic        CTRLCLK,
    input  logic        KEY,
    input  logic [7:0]  STEPS,
    input  logic        HALT,
    output logic        CLKEN,
    output logic [1:0]  ESTADO,
    output logic [31:0] CICLOS
);

    localparam logic [1:0]      c_IDLE    = 2'b00;
    localparam logic [1:0]      c_BURST   = 2'b01;
    localparam logic [1:0]      c_AUTO    = 2'b10;
    localparam logic [1:0]      c_HALTED  = 2'b11;
    localparam logic [CNTW-1:0] c_DIV_MAX = CNTW'(DIVISOR);
    localparam logic [CNTW-1:0] c_DB_LAST = CNTW'(DEBOUNCE - 1);
    localparam logic [CNTW-1:0] c_CNT_ONE = CNTW'(1);

    logic            r_sync1;
    logic            r_sync2;
    logic [CNTW-1:0] r_db_cnt;
    logic            r_key_db;
    logic            r_key_db_d;
    logic            w_press;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [CNTW-1:0] r_div;
    logic [7:0]      r_remaining;
    logic            r_clken;
    logic [31:0]     r_ciclos;

    logic            w_strobe;
    logic            w_div_clr;
    logic            w_div_inc;
    logic            w_load;
    logic [7:0]      w_steps_load;

    // Key is idle-high, so the synchronizer resets to the released level.
    always_ff @(posedge CLKFPGA or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= KEY;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLKFPGA or posedge RST) begin
        if (RST) begin
            r_db_cnt   <= '0;
            r_key_db   <= 1'b1;
            r_key_db_d <= 1'b1;
        end else begin
            r_key_db_d <= r_key_db;
            if (r_sync2 == r_key_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_key_db <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_CNT_ONE;
            end
        end
    end

    assign w_press      = r_key_db_d & ~r_key_db;
    assign w_steps_load = (STEPS == 8'd0) ? 8'd1 : STEPS;

    always_ff @(posedge CLKFPGA or posedge RST) begin
        if (RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (!CTRLCLK) begin
                    w_next = c_AUTO;
                end else if (w_press) begin
                    w_next = c_BURST;
                end
            end
            c_BURST: begin
                if (r_remaining <= 8'd1) begin
                    w_next = c_IDLE;
                end
            end
            c_AUTO: begin
                if (CTRLCLK) begin
                    w_next = c_IDLE;
                end else if (HALT) begin
                    w_next = c_HALTED;
                end
            end
            c_HALTED: begin
                if (CTRLCLK) begin
                    w_next = c_IDLE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    // HALT outranks a divider terminal count, so a breakpoint never leaks a strobe.
    always_comb begin
        w_strobe  = 1'b0;
        w_div_clr = 1'b0;
        w_div_inc = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!CTRLCLK) begin
                    w_div_clr = 1'b1;
                end else if (w_press) begin
                    w_load = 1'b1;
                end
            end
            c_BURST: begin
                w_strobe = 1'b1;
            end
            c_AUTO: begin
                if (CTRLCLK) begin
                    w_div_clr = 1'b1;
                end else if (!HALT) begin
                    if (r_div == c_DIV_MAX) begin
                        w_strobe  = 1'b1;
                        w_div_clr = 1'b1;
                    end else begin
                        w_div_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_strobe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLKFPGA or posedge RST) begin
        if (RST) begin
            r_div       <= '0;
            r_remaining <= 8'd0;
            r_clken     <= 1'b0;
            r_ciclos    <= 32'd0;
        end else begin
            if (w_div_clr) begin
                r_div <= '0;
            end else if (w_div_inc) begin
                r_div <= r_div + c_CNT_ONE;
            end

            if (w_load) begin
                r_remaining <= w_steps_load;
            end else if (r_state == c_BURST) begin
                r_remaining <= r_remaining - 8'd1;
            end

            r_clken <= w_strobe;
            if (w_strobe) begin
                r_ciclos <= r_ciclos + 32'd1;
            end
        end
    end

    assign CLKEN  = r_clken;
    assign ESTADO = r_state;
    assign CICLOS = r_ciclos;

endmodule
`default_nettype wire
